// File: rtl/load_controller.sv
// load_controller: streams a tile from memory into four operand
// buffers, one 16-byte chunk and one outstanding read at a time.
module load_controller (
  input  logic         clk,
  input  logic         rst,
  input  logic         can_do_load,
  input  logic [31:0]  tile_addr,
  input  logic [31:0]  tile_stride,
  input  logic [4:0]   msize,
  input  logic [4:0]   ksize,
  input  logic [3:0]   buffer_full,
  input  logic         interface_valid,
  input  logic [127:0] interface_rdata,
  output logic         interface_en,
  output logic         interface_rdwr,
  output logic [4:0]   interface_control,
  output logic [31:0]  current_addr,
  output logic [3:0]   wr_buf,
  output logic [127:0] buf_wdata,
  output logic         busy,
  output logic         done_load
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]   r_state;
  logic [1:0]   w_next;

  logic [31:0]  r_row_addr;
  logic [31:0]  r_pitch;
  logic [4:0]   r_msize;
  logic [4:0]   r_ksize;
  logic [4:0]   r_row;
  logic [1:0]   r_chunk;

  logic [4:0]   w_kclamp;
  logic         w_zero;
  logic [4:0]   w_ksum;
  logic [2:0]   w_nch;
  logic [4:0]   w_left;
  logic [2:0]   w_rem;
  logic         w_last_chunk;
  logic         w_last_row;
  logic         w_full;
  logic         w_issue;
  logic         w_wr;
  logic [127:0] w_mask_data;
  logic         w_unused;

  // The top two stride bits fall off the word-to-byte shift.
  assign w_unused = &{1'b0, tile_stride[31:30]};

  assign w_kclamp = (ksize > 5'd16) ? 5'd16 : ksize;
  assign w_zero   = (msize == 5'd0) || (w_kclamp == 5'd0);

  // Chunk geometry of the latched row width.
  assign w_ksum       = r_ksize + 5'd3;
  assign w_nch        = w_ksum[4:2];
  assign w_left       = r_ksize - {1'b0, r_chunk, 2'b00};
  assign w_rem        = (w_left >= 5'd4) ? 3'd4 : w_left[2:0];
  assign w_last_chunk = ({1'b0, r_chunk} == (w_nch - 3'd1));
  assign w_last_row   = (r_row == (r_msize - 5'd1));

  assign w_full  = buffer_full[r_chunk];
  assign w_issue = (r_state == S_REQ) && !w_full;
  assign w_wr    = (r_state == S_WAIT) && interface_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (can_do_load) w_next = w_zero ? S_DONE : S_REQ;
      end
      S_REQ: begin
        if (!w_full) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (interface_valid)
          w_next = (w_last_chunk && w_last_row) ? S_IDLE : S_REQ;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Tile parameters, row/chunk counters and row base address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row_addr <= 32'd0;
      r_pitch    <= 32'd0;
      r_msize    <= 5'd0;
      r_ksize    <= 5'd0;
      r_row      <= 5'd0;
      r_chunk    <= 2'd0;
    end else if (r_state == S_IDLE) begin
      if (can_do_load) begin
        r_row_addr <= tile_addr;
        r_pitch    <= {tile_stride[29:0], 2'b00};
        r_msize    <= msize;
        r_ksize    <= w_kclamp;
        r_row      <= 5'd0;
        r_chunk    <= 2'd0;
      end
    end else if (w_wr) begin
      if (!w_last_chunk) begin
        r_chunk <= r_chunk + 2'd1;
      end else if (!w_last_row) begin
        r_chunk    <= 2'd0;
        r_row      <= r_row + 5'd1;
        r_row_addr <= r_row_addr + r_pitch;
      end else begin
        r_chunk <= 2'd0;
        r_row   <= 5'd0;
      end
    end
  end

  // Zero the words past the end of a short final chunk.
  always_comb begin
    w_mask_data = interface_rdata;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) >= w_rem) w_mask_data[32*i +: 32] = 32'd0;
    end
  end

  // Outputs; all forced low while reset is held.
  always_comb begin
    interface_en      = 1'b0;
    interface_rdwr    = 1'b0;
    interface_control = 5'd0;
    current_addr      = 32'd0;
    wr_buf            = 4'd0;
    buf_wdata         = 128'd0;
    busy              = 1'b0;
    done_load         = 1'b0;
    if (!rst) begin
      busy = (r_state != S_IDLE);
      if (w_issue) begin
        interface_en      = 1'b1;
        interface_control = {w_rem, 2'b00};
        current_addr      = r_row_addr + {26'd0, r_chunk, 4'b0000};
      end
      if (w_wr) begin
        wr_buf    = 4'b0001 << r_chunk;
        buf_wdata = w_mask_data;
      end
      done_load = (r_state == S_DONE) ||
                  (w_wr && w_last_chunk && w_last_row);
    end
  end

endmodule
